// File: rtl/muldiv_ctrl_if.sv
// rtl/muldiv_ctrl_if.sv - command/operand bundle between the core and the HI/LO multiply/divide sequencer
interface muldiv_ctrl_if #(
   parameter int XLEN = 32
);
   logic            InValid;
   logic [31:0]     Ins;
   logic [XLEN-1:0] Rdata1;
   logic [XLEN-1:0] Rdata2;
   logic            Busy;
   logic [XLEN-1:0] MFdata;
   logic [XLEN-1:0] HI;
   logic [XLEN-1:0] LO;

   modport master (
      output InValid, Ins, Rdata1, Rdata2,
      input  Busy, MFdata, HI, LO
   );

   modport slave (
      input  InValid, Ins, Rdata1, Rdata2,
      output Busy, MFdata, HI, LO
   );
endinterface

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - iterative MULT/DIV sequencer owning HI/LO; MULDIV_FAST_MULT_EN makes MULT/MULTU single-cycle
// Busy stalls the core for XLEN cycles per mul/div; MF* read HI/LO combinationally in IDLE.
module muldiv_ctrl #(
   parameter int XLEN = 32
) (
   input  logic         CLK,
   input  logic         RST,
   muldiv_ctrl_if.slave bus
);
   localparam int CW = $clog2(XLEN);
   localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

   state_t            state_q;
   logic              busy_q;
   logic [XLEN-1:0]   hi_q;
   logic [XLEN-1:0]   lo_q;
   logic [XLEN-1:0]   mcand_q;
   logic [2*XLEN-1:0] work_q;
   logic [CW-1:0]     cnt_q;
   logic              neg_lo_q;
   logic              neg_hi_q;

   logic              dec;
   logic [5:0]        funct;
   logic              is_mfhi, is_mflo, is_mthi, is_mtlo, is_mul, is_div;
   logic              op_signed, rs_neg, rt_neg;
   logic [XLEN-1:0]   abs_rs, abs_rt;
   logic              unused_ins;

   assign dec        = bus.InValid && (bus.Ins[31:26] == 6'd0);
   assign funct      = bus.Ins[5:0];
   assign unused_ins = ^bus.Ins[25:6];

   assign is_mfhi = dec && (funct == 6'h10);
   assign is_mthi = dec && (funct == 6'h11);
   assign is_mflo = dec && (funct == 6'h12);
   assign is_mtlo = dec && (funct == 6'h13);
   assign is_mul  = dec && ((funct == 6'h18) || (funct == 6'h19));
   assign is_div  = dec && ((funct == 6'h1A) || (funct == 6'h1B));

   // Even funct codes (MULT/DIV) are the signed variants.
   assign op_signed = ~funct[0];
   assign rs_neg    = op_signed & bus.Rdata1[XLEN-1];
   assign rt_neg    = op_signed & bus.Rdata2[XLEN-1];
   assign abs_rs    = rs_neg ? -bus.Rdata1 : bus.Rdata1;
   assign abs_rt    = rt_neg ? -bus.Rdata2 : bus.Rdata2;

   logic [XLEN:0]     mul_acc;
   logic [2*XLEN-1:0] mul_next;
   logic [2*XLEN-1:0] mul_fin;
   logic [XLEN:0]     div_trial;
   logic [2*XLEN-1:0] div_next;
   logic [XLEN-1:0]   div_fin_lo;
   logic [XLEN-1:0]   div_fin_hi;

   // work_q holds {partial product, multiplier} for MUL and {remainder, dividend} for DIV.
   always_comb begin
      mul_acc   = {1'b0, work_q[2*XLEN-1:XLEN]} + {1'b0, (work_q[0] ? mcand_q : {XLEN{1'b0}})};
      mul_next  = {mul_acc, work_q[XLEN-1:1]};
      mul_fin   = neg_lo_q ? -mul_next : mul_next;
      div_trial = {work_q[2*XLEN-1:XLEN], work_q[XLEN-1]} - {1'b0, mcand_q};
      if (!div_trial[XLEN]) begin
         div_next = {div_trial[XLEN-1:0], work_q[XLEN-2:0], 1'b1};
      end else begin
         div_next = {work_q[2*XLEN-2:0], 1'b0};
      end
      div_fin_lo = neg_lo_q ? -div_next[XLEN-1:0] : div_next[XLEN-1:0];
      div_fin_hi = neg_hi_q ? -div_next[2*XLEN-1:XLEN] : div_next[2*XLEN-1:XLEN];
   end

`ifdef MULDIV_FAST_MULT_EN
   logic [2*XLEN-1:0] ext_rs, ext_rt, fast_prod;
   assign ext_rs    = {{XLEN{rs_neg}}, bus.Rdata1};
   assign ext_rt    = {{XLEN{rt_neg}}, bus.Rdata2};
   assign fast_prod = ext_rs * ext_rt;
`endif

   always_comb begin
      bus.MFdata = '0;
      if (state_q == S_IDLE) begin
         if (is_mfhi) begin
            bus.MFdata = hi_q;
         end else if (is_mflo) begin
            bus.MFdata = lo_q;
         end
      end
   end

   assign bus.Busy = busy_q;
   assign bus.HI   = hi_q;
   assign bus.LO   = lo_q;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q  <= S_IDLE;
         busy_q   <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         mcand_q  <= '0;
         work_q   <= '0;
         cnt_q    <= '0;
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (is_mthi) begin
                  hi_q <= bus.Rdata1;
               end else if (is_mtlo) begin
                  lo_q <= bus.Rdata1;
               end else if (is_mul) begin
`ifdef MULDIV_FAST_MULT_EN
                  hi_q <= fast_prod[2*XLEN-1:XLEN];
                  lo_q <= fast_prod[XLEN-1:0];
`else
                  state_q  <= S_MUL;
                  busy_q   <= 1'b1;
                  cnt_q    <= '0;
                  mcand_q  <= abs_rs;
                  work_q   <= {{XLEN{1'b0}}, abs_rt};
                  neg_lo_q <= rs_neg ^ rt_neg;
                  neg_hi_q <= 1'b0;
`endif
               end else if (is_div) begin
                  state_q  <= S_DIV;
                  busy_q   <= 1'b1;
                  cnt_q    <= '0;
                  mcand_q  <= abs_rt;
                  work_q   <= {{XLEN{1'b0}}, abs_rs};
                  // A zero divisor leaves the all-ones quotient unsigned.
                  neg_lo_q <= (rs_neg ^ rt_neg) && (bus.Rdata2 != '0);
                  neg_hi_q <= rs_neg;
               end
            end
            S_MUL: begin
               if (cnt_q == LAST) begin
                  hi_q    <= mul_fin[2*XLEN-1:XLEN];
                  lo_q    <= mul_fin[XLEN-1:0];
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  cnt_q   <= '0;
               end else begin
                  work_q <= mul_next;
                  cnt_q  <= cnt_q + 1'b1;
               end
            end
            S_DIV: begin
               if (cnt_q == LAST) begin
                  hi_q    <= div_fin_hi;
                  lo_q    <= div_fin_lo;
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  cnt_q   <= '0;
               end else begin
                  work_q <= div_next;
                  cnt_q  <= cnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - directed table-driven bench for muldiv_ctrl plus multi-cycle corner sequences
module tb_muldiv_ctrl;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   muldiv_ctrl_if #(.XLEN(32)) bus ();
   muldiv_ctrl #(.XLEN(32)) dut (.CLK(clk), .RST(rst_n), .bus(bus));

`ifdef MULDIV_FAST_MULT_EN
   localparam int          MC     = 0;
   localparam logic [5:0]  SEQ_F  = 6'h1B;
   localparam logic [31:0] SEQ_A  = 32'd84;
   localparam logic [31:0] SEQ_B  = 32'd2;
`else
   localparam int          MC     = 32;
   localparam logic [5:0]  SEQ_F  = 6'h19;
   localparam logic [31:0] SEQ_A  = 32'd6;
   localparam logic [31:0] SEQ_B  = 32'd7;
`endif

   typedef struct {
      string       name;
      logic [5:0]  op;
      logic [5:0]  f;
      logic [31:0] rs;
      logic [31:0] rt;
      int          cyc;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t vecs[15];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [5:0] op, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      bus.InValid = 1'b1;
      bus.Ins     = {op, 20'd0, f};
      bus.Rdata1  = a;
      bus.Rdata2  = b;
   endtask

   task automatic issue(input logic [5:0] op, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      drive(op, f, a, b);
      @(posedge clk);
      #1;
      bus.InValid = 1'b0;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (bus.Busy && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      vecs[0]  = '{"multu_max",   6'h00, 6'h19, 32'hFFFFFFFF, 32'h00000002, MC, 32'h00000001, 32'hFFFFFFFE};
      vecs[1]  = '{"mult_neg",    6'h00, 6'h18, 32'hFFFFFFFD, 32'h00000007, MC, 32'hFFFFFFFF, 32'hFFFFFFEB};
      vecs[2]  = '{"div_neg",     6'h00, 6'h1A, 32'hFFFFFFF9, 32'h00000002, 32, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[3]  = '{"divu_zero",   6'h00, 6'h1B, 32'd100,      32'h00000000, 32, 32'd100,      32'hFFFFFFFF};
      vecs[4]  = '{"div_ovf",     6'h00, 6'h1A, 32'h80000000, 32'hFFFFFFFF, 32, 32'h00000000, 32'h80000000};
      vecs[5]  = '{"mthi",        6'h00, 6'h11, 32'h00001234, 32'h0,        0,  32'h00001234, 32'h80000000};
      vecs[6]  = '{"mtlo",        6'h00, 6'h13, 32'h0000CAFE, 32'h0,        0,  32'h00001234, 32'h0000CAFE};
      vecs[7]  = '{"mult_negneg", 6'h00, 6'h18, 32'hFFFFFFFC, 32'hFFFFFFFB, MC, 32'h00000000, 32'h00000014};
      vecs[8]  = '{"divu_big",    6'h00, 6'h1B, 32'hFFFFFFFF, 32'h00000010, 32, 32'h0000000F, 32'h0FFFFFFF};
      vecs[9]  = '{"div_negrt",   6'h00, 6'h1A, 32'h00000007, 32'hFFFFFFFE, 32, 32'h00000001, 32'hFFFFFFFD};
      vecs[10] = '{"div_zero_s",  6'h00, 6'h1A, 32'hFFFFFFFB, 32'h00000000, 32, 32'hFFFFFFFB, 32'hFFFFFFFF};
      vecs[11] = '{"multu_shift", 6'h00, 6'h19, 32'h12345678, 32'h00000010, MC, 32'h00000001, 32'h23456780};
      vecs[12] = '{"funct_ign",   6'h00, 6'h20, 32'hDEADBEEF, 32'h1,        0,  32'h00000001, 32'h23456780};
      vecs[13] = '{"mult_minsq",  6'h00, 6'h18, 32'h80000000, 32'h80000000, MC, 32'h40000000, 32'h00000000};
      vecs[14] = '{"opcode_ign",  6'h08, 6'h11, 32'hDEADBEEF, 32'h0,        0,  32'h40000000, 32'h00000000};

      bus.InValid = 1'b0;
      bus.Ins     = '0;
      bus.Rdata1  = '0;
      bus.Rdata2  = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", {31'd0, bus.Busy}, 32'd0);
      chk("rst_hi", bus.HI, 32'd0);
      chk("rst_lo", bus.LO, 32'd0);
      chk("rst_mfdata", bus.MFdata, 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 15; i++) begin
         issue(vecs[i].op, vecs[i].f, vecs[i].rs, vecs[i].rt);
         wait_idle(n);
         chk({vecs[i].name, "_cyc"}, 32'(n), 32'(vecs[i].cyc));
         chk({vecs[i].name, "_hi"}, bus.HI, vecs[i].hi);
         chk({vecs[i].name, "_lo"}, bus.LO, vecs[i].lo);
      end

      // MTHI then MFHI: combinational read, never busy
      issue(6'h00, 6'h11, 32'h00001234, 32'h0);
      chk("mthi_busy", {31'd0, bus.Busy}, 32'd0);
      drive(6'h00, 6'h10, 32'h0, 32'h0);
      #1;
      chk("mfhi_data", bus.MFdata, 32'h00001234);
      @(posedge clk);
      #1;
      bus.InValid = 1'b0;

      // MF* and mul/mt commands while busy are dropped
      issue(6'h00, SEQ_F, SEQ_A, SEQ_B);
      chk("seq_busy", {31'd0, bus.Busy}, 32'd1);
      drive(6'h00, 6'h12, 32'h0, 32'h0);
      #1;
      chk("mflo_busy", bus.MFdata, 32'd0);
      @(posedge clk);
      #1;
      bus.InValid = 1'b0;
      issue(6'h00, 6'h19, 32'd3, 32'd3);
      issue(6'h00, 6'h13, 32'h00000BAD, 32'h0);
      chk("seq_lo_stable", bus.LO, 32'h00000000);
      wait_idle(n);
      chk("seq_hi", bus.HI, 32'd0);
      chk("seq_lo", bus.LO, 32'd42);
      drive(6'h00, 6'h12, 32'h0, 32'h0);
      #1;
      chk("mflo_after", bus.MFdata, 32'd42);
      @(posedge clk);
      #1;
      bus.InValid = 1'b0;
      issue(6'h00, 6'h19, 32'd3, 32'd3);
      wait_idle(n);
      chk("reissue_hi", bus.HI, 32'd0);
      chk("reissue_lo", bus.LO, 32'd9);

      // MULTU 6x7 on the accept edge
      issue(6'h00, 6'h19, 32'd6, 32'd7);
`ifdef MULDIV_FAST_MULT_EN
      chk("fast_busy", {31'd0, bus.Busy}, 32'd0);
      chk("fast_lo", bus.LO, 32'd42);
`else
      chk("iter_busy", {31'd0, bus.Busy}, 32'd1);
      chk("iter_lo_held", bus.LO, 32'd9);
`endif
      wait_idle(n);
      chk("mul67_lo", bus.LO, 32'd42);

      // reset mid-DIV aborts with nothing written
      issue(6'h00, 6'h1B, 32'd100, 32'd3);
      repeat (9) @(negedge clk);
      chk("mid_busy", {31'd0, bus.Busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", {31'd0, bus.Busy}, 32'd0);
      chk("abort_hi", bus.HI, 32'd0);
      chk("abort_lo", bus.LO, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(6'h00, 6'h12, 32'h0, 32'h0);
      #1;
      chk("abort_mflo", bus.MFdata, 32'd0);
      @(posedge clk);
      #1;
      bus.InValid = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      chk("abort_late_lo", bus.LO, 32'd0);
      chk("abort_late_busy", {31'd0, bus.Busy}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Multi-cycle multiply/divide sequencer that owns the HI/LO register pair of the single-clock MIPS core.
- Sits beside EX. It decodes R-form MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO, runs iterative shift-add multiply and restoring divide over XLEN cycles, and holds Busy high so the core freezes PC and register writes until HI/LO are valid.
- MFHI/MFLO results feed the register-file write mux.

Parameters:
- XLEN, 32, operand width; also the iteration count of one mul/div.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-low.
- InValid  in  1  Ins/Rdata1/Rdata2 are valid this cycle.
- Ins  in  32  current instruction.
- Rdata1  in  XLEN  rs value.
- Rdata2  in  XLEN  rt value.
- Busy  out  1  sequencer running; the core must stall.
- MFdata  out  XLEN  HI or LO for MFHI/MFLO, otherwise 0.
- HI  out  XLEN  HI register.
- LO  out  XLEN  LO register.

Behaviour:
- Decode condition: Ins[31:26]==0 and InValid. Funct codes:
  - MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13.
  - MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B.
  - All other funct values are ignored.
- Reset (RST low, asynchronous): state=IDLE, Busy=0, HI=0, LO=0, counter=0, work registers=0. MFdata is then 0.
- States:
  - IDLE: accepts commands.
  - MUL: shift-add multiply, one bit per cycle.
  - DIV: restoring divide, one quotient bit per cycle.
- Accept:
  - In IDLE, a decoded MULT* or DIV* on an edge latches the operands and signedness, clears counter, goes to MUL or DIV, and sets Busy=1.
- Signed operations (MULT/DIV):
  - Operate on absolute values.
  - Product sign = sign(rs) XOR sign(rt).
  - Quotient sign = sign(rs) XOR sign(rt); remainder sign = sign(rs).
  - Negation is applied in the final cycle.
- Iteration:
  - Counter increments each cycle.
  - On the edge where counter==XLEN-1: write the result to HI/LO, go to IDLE, set Busy=0.
  - Busy is therefore high for exactly XLEN cycles after the accept edge.
- Results:
  - MUL: HI = product[2*XLEN-1:XLEN], LO = product[XLEN-1:0].
  - DIV: LO = quotient, HI = remainder.
- Divide by zero: no trap; runs the full XLEN cycles; final LO = all ones, HI = rs.
- Signed overflow (-2^(XLEN-1) / -1): LO = 0x80000000, HI = 0. No exception.
- MTHI/MTLO: in IDLE, HI (or LO) <= Rdata1 on the edge; no Busy.
- MFHI/MFLO: MFdata = HI/LO combinationally while the instruction is decoded and state==IDLE.
- Any decoded command while Busy=1 is ignored and not queued. The core holds the instruction because Busy stalls it, so it is re-presented after Busy falls.
- HI/LO change only on the completion edge or an MT* edge; they are stable throughout a run.
- Reset mid-operation aborts immediately: HI/LO=0, nothing partial is written.
- Simultaneous MT* and completion cannot occur, because MT* is ignored while busy.

Optional Feature:
- Macro MULDIV_FAST_MULT_EN.
  - Defined: MULT/MULTU complete combinationally. HI/LO are written on the accept edge, MUL state is unused, and Busy stays 0. DIV behaviour is unchanged.
  - Undefined: the XLEN-cycle iterative multiply described above.

Test Plan:
- Reset low mid-DIV (cycle 10) -> Busy=0, HI=0, LO=0 immediately; a subsequent MFLO gives MFdata=0.
- MULTU rs=0xFFFFFFFF, rt=0x2 -> Busy high 32 cycles; then HI=0x00000001, LO=0xFFFFFFFE.
- MULT rs=-3 (0xFFFFFFFD), rt=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV rs=-7, rt=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU rs=100, rt=0 -> LO=0xFFFFFFFF, HI=100.
- MTHI 0x1234 then MFHI -> MFdata=0x1234 with no Busy. MFLO issued during MULT -> ignored while Busy; re-presented after completion, returns the new LO.
- Back-to-back MULT issued while Busy -> second ignored; HI/LO reflect only the first until re-issued. With MULDIV_FAST_MULT_EN: MULTU 6×7 -> LO=42 on the accept edge, Busy never asserted.
